// File: rtl/mesi_isc_breq_rr_arb.sv
// mesi_isc_breq_rr_arb: round-robin arbiter moving per-CPU breq FIFO heads into the broadcast FIFO
module mesi_isc_breq_rr_arb #(
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    fifo_status_empty_array,
    input  logic [4*BROAD_TYPE_WIDTH-1:0] fifo_type_array,
    input  logic [4*ADDR_WIDTH-1:0]       fifo_addr_array,
    input  logic                          broad_fifo_status_full_i,
    output logic [3:0]                    fifo_rd_array,
    output logic                          broad_fifo_wr_o,
    output logic [ADDR_WIDTH-1:0]         broad_addr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
    output logic [1:0]                    broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
    output logic                          err_type_o
);
    typedef enum logic {IDLE, GAP} state_t;
    state_t state, state_nx;
    logic [1:0] last_grant, win;
    logic [4:0] seq [4];
    logic grant, is_err;
    logic [BROAD_TYPE_WIDTH-1:0] win_type;
    logic [ADDR_WIDTH-1:0] win_addr;
    always_comb begin
        win = last_grant;
        // scanning from farthest to nearest leaves the nearest eligible CPU as winner
        for (int k = 4; k >= 1; k--)
            if (!fifo_status_empty_array[last_grant + 2'(k)]) win = last_grant + 2'(k);
        win_type = fifo_type_array[int'(win)*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
        win_addr = fifo_addr_array[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        grant = state == IDLE && !(&fifo_status_empty_array) && !broad_fifo_status_full_i;
        is_err = win_type == BROAD_TYPE_WIDTH'(3);
        state_nx = grant ? GAP : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fifo_rd_array <= '0;
            broad_fifo_wr_o <= 1'b0;
            broad_addr_o <= '0;
            broad_type_o <= '0;
            broad_cpu_id_o <= '0;
            broad_id_o <= '0;
            err_type_o <= 1'b0;
            last_grant <= 2'd3;
            for (int i = 0; i < 4; i++) seq[i] <= '0;
        end else begin
            state <= state_nx;
            fifo_rd_array <= grant ? 4'b0001 << win : 4'b0000;
            broad_fifo_wr_o <= grant && !is_err;
            if (grant) begin
                last_grant <= win;
                broad_cpu_id_o <= win;
                if (is_err) err_type_o <= 1'b1;
                else begin
                    broad_addr_o <= win_addr;
                    broad_type_o <= win_type;
                    broad_id_o <= BROAD_ID_WIDTH'({win, seq[win]});
                    seq[win] <= seq[win] + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mesi_isc_breq_rr_arb.sv
// tb_mesi_isc_breq_rr_arb: directed and random checks of the breq arbiter against a behavioural model
module tb_mesi_isc_breq_rr_arb;
    logic clk = 0, rst = 1, full = 0;
    logic [3:0] empty = 4'hf;
    logic [7:0] type_arr = '0;
    logic [127:0] addr_arr = '0;
    logic [3:0] rd;
    logic wr, err;
    logic [31:0] addr;
    logic [1:0] btype, cpu;
    logic [6:0] id;
    int n = 0, errs = 0;
    int lg, seq [4];
    bit gap;
    logic [3:0] e_rd;
    logic e_wr, e_err;
    logic [31:0] e_addr;
    logic [1:0] e_type, e_cpu;
    logic [6:0] e_id;

    mesi_isc_breq_rr_arb dut (
        .clk(clk), .rst(rst), .fifo_status_empty_array(empty), .fifo_type_array(type_arr),
        .fifo_addr_array(addr_arr), .broad_fifo_status_full_i(full), .fifo_rd_array(rd),
        .broad_fifo_wr_o(wr), .broad_addr_o(addr), .broad_type_o(btype),
        .broad_cpu_id_o(cpu), .broad_id_o(id), .err_type_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("fifo_rd", 64'(rd), 64'(e_rd));
        chk("wr", 64'(wr), 64'(e_wr));
        chk("addr", 64'(addr), 64'(e_addr));
        chk("type", 64'(btype), 64'(e_type));
        chk("cpu", 64'(cpu), 64'(e_cpu));
        chk("id", 64'(id), 64'(e_id));
        chk("err", 64'(err), 64'(e_err));
    endtask

    task automatic model_reset();
        lg = 3; gap = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        e_rd = 0; e_wr = 0; e_err = 0; e_addr = 0; e_type = 0; e_cpu = 0; e_id = 0;
    endtask

    // one arbitration opportunity evaluated from the inputs seen at this edge
    task automatic model_step();
        int w;
        w = -1;
        if (!gap && !full)
            for (int k = 1; k <= 4; k++)
                if (w < 0 && !empty[(lg + k) % 4]) w = (lg + k) % 4;
        e_rd = 0; e_wr = 0;
        if (w >= 0) begin
            e_rd[w] = 1'b1;
            lg = w;
            e_cpu = 2'(w);
            if (type_arr[w*2 +: 2] == 2'd3) e_err = 1;
            else begin
                e_wr = 1;
                e_addr = addr_arr[w*32 +: 32];
                e_type = type_arr[w*2 +: 2];
                e_id = 7'(w * 32 + seq[w]);
                seq[w] = (seq[w] + 1) % 32;
            end
            gap = 1;
        end else gap = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1 chk_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1 chk_all();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        empty = 4'b1110; addr_arr[31:0] = 32'h100; type_arr[1:0] = 2'd1;
        tick();
        tick();
        do_reset();
        empty = 4'b0000; type_arr = 8'b00_10_01_00;
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        full = 1;
        for (int i = 0; i < 5; i++) tick();
        full = 0;
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        empty = 4'b1011; type_arr = 8'b00_11_00_00; addr_arr[95:64] = 32'hcafe;
        tick();
        type_arr[5:4] = 2'd1;
        for (int i = 0; i < 4; i++) tick();
        chk("err_sticky", 64'(err), 64'd1);
        do_reset();
        empty = 4'b1101; type_arr = 8'b00_00_10_00;
        for (int i = 0; i < 66; i++) begin
            addr_arr[63:32] = 32'(i);
            tick();
        end
        chk("seq_wrap_id", 64'(id), 64'h20);
        do_reset();
        empty = 4'b0000; type_arr = '0;
        tick();
        rst = 1;
        model_reset();
        #1 chk_all();
        @(negedge clk);
        rst = 0;
        tick();
        chk("post_reset_cpu", 64'(cpu), 64'd0);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            empty = 4'($urandom);
            full = $urandom_range(0, 3) == 0;
            for (int c = 0; c < 4; c++) begin
                type_arr[c*2 +: 2] = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
                addr_arr[c*32 +: 32] = $urandom;
            end
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/mesi_isc_breq_rr_arb.md
MESI_ISC_BREQ_RR_ARB -- requirements
Module: mesi_isc_breq_rr_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, broadcast address width.
REQ-002 The block SHALL have parameter BROAD_TYPE_WIDTH, default 2, broadcast type width.
REQ-003 The block SHALL have parameter BROAD_ID_WIDTH, default 7, broadcast id width: {cpu[1:0], seq[4:0]}.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fifo_status_empty_array  input  4  per-CPU breq FIFO empty flag; bit n belongs to CPU n.
REQ-007 fifo_type_array  input  4*BROAD_TYPE_WIDTH  head-entry type of each FIFO; slice n belongs to CPU n.
REQ-008 fifo_addr_array  input  4*ADDR_WIDTH  head-entry address of each FIFO; slice n belongs to CPU n.
REQ-009 broad_fifo_status_full_i  input  1  broadcast FIFO full.
REQ-010 fifo_rd_array  output  4  one-hot pop pulse to the breq FIFOs.
REQ-011 broad_fifo_wr_o  output  1  broadcast FIFO write pulse.
REQ-012 broad_addr_o  output  ADDR_WIDTH  broadcast address.
REQ-013 broad_type_o  output  BROAD_TYPE_WIDTH  broadcast type.
REQ-014 broad_cpu_id_o  output  2  originating CPU.
REQ-015 broad_id_o  output  BROAD_ID_WIDTH  broadcast id.
REQ-016 err_type_o  output  1  sticky flag: an entry with type 3 was popped.

Function
REQ-017 FSM states SHALL be IDLE and GAP; every output SHALL be registered.
REQ-018 IDLE: a CPU n is eligible when fifo_status_empty_array[n]=0.
REQ-019 IDLE with at least one eligible CPU and broad_fifo_status_full_i=0: the winner SHALL be the first eligible CPU in order last_grant+1, +2, +3, +4 (mod 4), and the FSM SHALL go to GAP.
REQ-020 On that edge the block SHALL set fifo_rd_array=onehot(winner), last_grant=winner and broad_cpu_id_o=winner.
REQ-021 If the winner's type is not 3, the same edge SHALL set broad_fifo_wr_o=1, broad_addr_o/broad_type_o from the winner's slices, broad_id_o={winner, seq[winner]}, and SHALL increment seq[winner], a 5-bit counter that wraps 31->0.
REQ-022 If the winner's type is 3, the same edge SHALL pop the entry (fifo_rd pulse only), keep broad_fifo_wr_o=0, leave seq unchanged and set err_type_o=1.
REQ-023 GAP SHALL last exactly one cycle: fifo_rd_array=0, broad_fifo_wr_o=0, next state IDLE; GAP lets the FIFO empty flags settle.
REQ-024 Pulses SHALL be one cycle wide, giving at most one grant per 2 cycles.
REQ-025 broad_addr_o, broad_type_o, broad_cpu_id_o and broad_id_o SHALL hold their value until the next grant.
REQ-026 IDLE with broad_fifo_status_full_i=1: no grant, no pop, the FSM stays in IDLE and last_grant is unchanged.
REQ-027 No eligible CPU: the FSM stays in IDLE with all pulses 0.
REQ-028 fifo_rd_array SHALL never assert a bit whose empty flag was 1 in the granting cycle.
REQ-029 broad_fifo_wr_o SHALL never assert in a cycle after full was sampled 1.
REQ-030 err_type_o SHALL be cleared only by rst.

Reset
REQ-031 When rst=1, the block SHALL immediately and asynchronously set: state=IDLE; fifo_rd_array=0; broad_fifo_wr_o=0; broad_addr_o=0; broad_type_o=0; broad_cpu_id_o=0; broad_id_o=0; err_type_o=0; last_grant=3; all seq=0.
REQ-032 A reset asserted during GAP or during a grant cycle SHALL abort the operation, and no pulse SHALL appear after rst rises.
REQ-033 After rst falls, the first grant SHALL be possible on the first rising edge.

Verification
REQ-034 Reset, then empty=4'b1110, addr0=0x100, type0=1 -> next cycle fifo_rd=0001, wr=1, addr=0x100, type=1, cpu=0, id=7'h00; the following cycle wr=0.
REQ-035 All four FIFOs non-empty continuously, full=0 -> grant order 0,1,2,3,0 on cycles 1,3,5,7,9; ids 0x00,0x20,0x40,0x60,0x01.
REQ-036 empty=4'b0000, full=1 for 5 cycles, then full=0 -> no pulses during the full window; the first grant goes to CPU0.
REQ-037 CPU2 head type=3, others empty -> fifo_rd=0100, wr=0, err_type_o=1 and stays 1; a later valid CPU2 request gets id 0x40.
REQ-038 Thirty-three grants to CPU1 -> the 33rd id equals 0x20 (seq wrap).
REQ-039 rst asserted asynchronously in a grant cycle -> outputs go to 0 before the next edge; the first post-reset grant goes to CPU0.
